// File: rtl/execute_cc.sv
// execute_cc: Y86-64 execute stage with a one-entry registered output and valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   decode stage presents an instruction
//   in_ready   stage accepts the instruction this cycle (combinational)
//   icode/ifun instruction code and function (4 bits each)
//   valA/valB  register operands (64 bits)
//   valC       immediate (64 bits)
//   out_valid  registered result present
//   out_ready  memory stage consumes the result
//   valE       registered execute result
//   cnd        registered condition outcome
//   icode_q    registered icode of the result
//   cc         condition codes {ZF,SF,OF}
//   err        sticky invalid-instruction flag
//
// Configuration
//   EXECUTE_CC_INVALID_TRAP_EN  when defined, accepting an invalid instruction sets err and
//                               stalls the input until rst; otherwise invalid instructions
//                               flow through with valE=0, cnd=0 and err is tied low.
module execute_cc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [3:0]  icode_q,
  output logic [2:0]  cc,
  output logic        err
);

  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] CcReset = 3'b100;

  logic        r_out_valid;
  logic [63:0] r_valE;
  logic        r_cnd;
  logic [3:0]  r_icode;
  logic [2:0]  r_cc;

  logic        w_xfer_in;
  logic        w_invalid;
  logic [63:0] w_alu_res;
  logic        w_alu_of;
  logic [63:0] w_valE;
  logic        w_cond;
  logic        w_cnd;
  logic        w_cc_upd;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;

  assign w_invalid = (icode > 4'hB) || ((icode == IOPQ) && (ifun > 4'h3));
  assign w_xfer_in = in_valid && in_ready;

  // ALU: operand order is valB op valA, so sub yields valB - valA.
  always_comb begin
    w_alu_res = '0;
    w_alu_of  = 1'b0;
    unique case (ifun[1:0])
      2'd0: begin
        w_alu_res = valB + valA;
        w_alu_of  = (valA[63] == valB[63]) && (w_alu_res[63] != valB[63]);
      end
      2'd1: begin
        w_alu_res = valB - valA;
        w_alu_of  = (valA[63] != valB[63]) && (w_alu_res[63] != valB[63]);
      end
      2'd2: w_alu_res = valB & valA;
      2'd3: w_alu_res = valB ^ valA;
      default: ;
    endcase
  end

  always_comb begin
    w_valE = '0;
    if (!w_invalid) begin
      case (icode)
        IRRMOVQ:          w_valE = valA;
        IIRMOVQ:          w_valE = valC;
        IRMMOVQ, IMRMOVQ: w_valE = valB + valC;
        IOPQ:             w_valE = w_alu_res;
        ICALL, IPUSHQ:    w_valE = valB - 64'd8;
        IRET, IPOPQ:      w_valE = valB + 64'd8;
        default:          w_valE = '0;
      endcase
    end
  end

  // Conditions read the committed CC, i.e. the value before this instruction's own update.
  assign w_zf = r_cc[2];
  assign w_sf = r_cc[1];
  assign w_of = r_cc[0];

  always_comb begin
    w_cond = 1'b0;
    case (ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (w_sf ^ w_of) | w_zf;
      4'd2:    w_cond = w_sf ^ w_of;
      4'd3:    w_cond = w_zf;
      4'd4:    w_cond = !w_zf;
      4'd5:    w_cond = !(w_sf ^ w_of);
      4'd6:    w_cond = !(w_sf ^ w_of) && !w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd    = ((icode == IRRMOVQ) || (icode == IJXX)) ? w_cond : 1'b0;
  assign w_cc_upd = w_xfer_in && (icode == IOPQ) && !w_invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_valE      <= '0;
      r_cnd       <= 1'b0;
      r_icode     <= '0;
      r_cc        <= CcReset;
    end else begin
      if (w_xfer_in) begin
        r_out_valid <= 1'b1;
        r_valE      <= w_valE;
        r_cnd       <= w_cnd;
        r_icode     <= icode;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_cc_upd) begin
        r_cc <= {(w_alu_res == 64'd0), w_alu_res[63], w_alu_of};
      end
    end
  end

`ifdef EXECUTE_CC_INVALID_TRAP_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_xfer_in && w_invalid) begin
      r_err <= 1'b1;
    end
  end

  // Once trapped, the stage refuses new work until reset.
  assign in_ready = (!r_out_valid || out_ready) && !r_err;
  assign err      = r_err;
`else
  assign in_ready = !r_out_valid || out_ready;
  assign err      = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign valE      = r_valE;
  assign cnd       = r_cnd;
  assign icode_q   = r_icode;
  assign cc        = r_cc;

endmodule
